// File: rtl/pixel_plotter_if.sv
// rtl/pixel_plotter_if.sv - pixel stream and VRAM write bus for pixel_plotter
interface pixel_plotter_if #(
    parameter int CORDW = 10,
    parameter int ADDRW = 16
);
    logic                    pix_valid_i;
    logic                    pix_ready_o;
    logic signed [CORDW-1:0] x_i;
    logic signed [CORDW-1:0] y_i;
    logic [3:0]              color_i;
    logic                    vram_sel_o;
    logic                    vram_wr_o;
    logic [3:0]              vram_mask_o;
    logic [ADDRW-1:0]        vram_addr_o;
    logic [15:0]             vram_data_o;
    logic                    vram_ack_i;

    // plotter side: consumes points, issues VRAM writes
    modport master (
        input  pix_valid_i,
        output pix_ready_o,
        input  x_i,
        input  y_i,
        input  color_i,
        output vram_sel_o,
        output vram_wr_o,
        output vram_mask_o,
        output vram_addr_o,
        output vram_data_o,
        input  vram_ack_i
    );

    // environment side: line generator and VRAM
    modport slave (
        output pix_valid_i,
        input  pix_ready_o,
        output x_i,
        output y_i,
        output color_i,
        input  vram_sel_o,
        input  vram_wr_o,
        input  vram_mask_o,
        input  vram_addr_o,
        input  vram_data_o,
        output vram_ack_i
    );
endinterface

// File: rtl/pixel_plotter.sv
// rtl/pixel_plotter.sv - clipped 4-bpp pixel writer with row-address cache
module pixel_plotter #(
    parameter int CORDW = 10,
    parameter int ADDRW = 16
) (
    input  logic             clk,
    input  logic             reset_n_i,
    pixel_plotter_if.master  bus,
    input  logic             inval_i,
    input  logic [ADDRW-1:0] base_addr_i,
    input  logic [ADDRW-1:0] stride_i,
    input  logic [CORDW-1:0] width_i,
    input  logic [CORDW-1:0] height_i,
    output logic             busy_o
);
    localparam int CNTW = $clog2(CORDW + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state;
    logic             ready_q;
    logic             sel_q;
    logic [3:0]       mask_q;
    logic [ADDRW-1:0] addr_q;
    logic [15:0]      data_q;

    // row cache: last drawn row and its start word address
    logic             row_valid;
    logic [CORDW-1:0] row_y;
    logic [ADDRW-1:0] row_addr;

    // miss path: word offset of the pending point and serial multiplier state
    logic [ADDRW-1:0] x_word_q;
    logic [ADDRW-1:0] mul_acc;
    logic [CORDW-1:0] mul_y;
    logic [CNTW-1:0]  mul_cnt;

    logic             accept;
    logic             clipped;
    logic [ADDRW-1:0] x_word;
    logic [3:0]       x_mask;
    logic             cache_ok;
    logic             row_hit;
    logic             row_dn;
    logic             row_up;
    logic [ADDRW-1:0] step_row;
    logic [ADDRW-1:0] mul_step;
    logic [ADDRW-1:0] miss_row;
    logic [CORDW:0]   row_y_inc;
    logic [CORDW-1:0] row_y_dec;

    assign accept = bus.pix_valid_i & ready_q;

    // bounds are unsigned; a negative coordinate is caught by its sign bit first
    assign clipped = bus.x_i[CORDW-1] | bus.y_i[CORDW-1]
                   | (bus.x_i >= width_i) | (bus.y_i >= height_i);

    assign x_word = ADDRW'(bus.x_i[CORDW-1:2]);
    assign x_mask = 4'b1000 >> bus.x_i[1:0];

    // an invalidate in the accept cycle wins, so that point takes the miss path
    assign cache_ok  = row_valid & ~inval_i;
    assign row_y_inc = {1'b0, row_y} + {{CORDW{1'b0}}, 1'b1};
    assign row_y_dec = row_y - {{(CORDW-1){1'b0}}, 1'b1};
    assign row_hit   = cache_ok & (bus.y_i == row_y);
    assign row_dn    = cache_ok & ({1'b0, bus.y_i} == row_y_inc);
    assign row_up    = cache_ok & (row_y != '0) & (bus.y_i == row_y_dec);

    assign step_row = row_hit ? row_addr :
                      row_dn  ? row_addr + stride_i :
                                row_addr - stride_i;

    // MSB-first shift-add: one bit of y per cycle, product truncated to ADDRW
    assign mul_step = {mul_acc[ADDRW-2:0], 1'b0} + (mul_y[CORDW-1] ? stride_i : '0);
    assign miss_row = base_addr_i + mul_step;

    assign bus.pix_ready_o = ready_q;
    assign bus.vram_sel_o  = sel_q;
    assign bus.vram_wr_o   = sel_q;
    assign bus.vram_mask_o = mask_q;
    assign bus.vram_addr_o = addr_q;
    assign bus.vram_data_o = data_q;
    assign busy_o          = (state != IDLE);

    // control FSM, row cache, multiplier and registered VRAM outputs
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            sel_q     <= 1'b0;
            mask_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            row_valid <= 1'b0;
            row_y     <= '0;
            row_addr  <= '0;
            x_word_q  <= '0;
            mul_acc   <= '0;
            mul_y     <= '0;
            mul_cnt   <= '0;
        end else begin
            if (inval_i) begin
                row_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (clipped) begin
                            row_valid <= 1'b0;
                        end else begin
                            ready_q   <= 1'b0;
                            row_valid <= 1'b1;
                            row_y     <= bus.y_i;
                            x_word_q  <= x_word;
                            mask_q    <= x_mask;
                            data_q    <= {4{bus.color_i}};
                            if (row_hit | row_dn | row_up) begin
                                row_addr <= step_row;
                                addr_q   <= step_row + x_word;
                                sel_q    <= 1'b1;
                                state    <= WRITE;
                            end else begin
                                mul_acc <= '0;
                                mul_y   <= bus.y_i;
                                mul_cnt <= '0;
                                state   <= MUL;
                            end
                        end
                    end
                end
                MUL: begin
                    mul_acc <= mul_step;
                    mul_y   <= mul_y << 1;
                    mul_cnt <= mul_cnt + CNTW'(1);
                    if (mul_cnt == CNTW'(CORDW - 1)) begin
                        row_addr <= miss_row;
                        addr_q   <= miss_row + x_word_q;
                        sel_q    <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.vram_ack_i) begin
                        sel_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_plotter.sv
// tb/tb_pixel_plotter.sv - directed self-checking bench for pixel_plotter
module tb_pixel_plotter;
    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        inval_i = 1'b0;
    logic [15:0] base_addr_i = '0;
    logic [15:0] stride_i = '0;
    logic [9:0]  width_i = '0;
    logic [9:0]  height_i = '0;
    logic        busy_o;
    int          errors = 0;
    int          checks = 0;
    int          writes = 0;

    pixel_plotter_if #(.CORDW(10), .ADDRW(16)) bus ();

    pixel_plotter #(.CORDW(10), .ADDRW(16)) dut (
        .clk         (clk),
        .reset_n_i   (reset_n_i),
        .bus         (bus),
        .inval_i     (inval_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .width_i     (width_i),
        .height_i    (height_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n_i && bus.vram_sel_o && bus.vram_ack_i) writes <= writes + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // present a point, wait for accept, return cycles from accept to sel (-1 if none)
    task automatic do_point(input logic [9:0] px, input logic [9:0] py, input logic [3:0] c,
                            input bit inv, output int lat);
        int n;
        bus.x_i = px;
        bus.y_i = py;
        bus.color_i = c;
        bus.pix_valid_i = 1'b1;
        n = 0;
        while (!bus.pix_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.pix_ready_o) begin
            bus.pix_valid_i = 1'b0;
            lat = -1;
            return;
        end
        inval_i = inv;
        @(posedge clk); #1;
        bus.pix_valid_i = 1'b0;
        inval_i = 1'b0;
        lat = 0;
        while (!bus.vram_sel_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.vram_sel_o) lat = -1;
    endtask

    task automatic do_ack();
        bus.vram_ack_i = 1'b1;
        @(posedge clk); #1;
        bus.vram_ack_i = 1'b0;
    endtask

    task automatic pulse_inval();
        inval_i = 1'b1;
        @(posedge clk); #1;
        inval_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.pix_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus.pix_ready_o); end
        checks++; if ({bus.vram_sel_o, bus.vram_wr_o, busy_o} !== 3'b000) begin errors++; $display("FAIL rst_sel_wr_busy: got %b expected 000", {bus.vram_sel_o, bus.vram_wr_o, busy_o}); end
        checks++; if ({bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_o} !== 36'h0) begin errors++; $display("FAIL rst_outputs: got %h expected 0", {bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_o}); end
        reset_n_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.pix_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", bus.pix_ready_o); end
    endtask

    task automatic test_cold_miss();
        int lat;
        base_addr_i = 16'h1000;
        stride_i = 16'd80;
        width_i = 10'd320;
        height_i = 10'd240;
        pulse_inval();
        do_point(10'd5, 10'd3, 4'hA, 1'b0, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL cold_lat: got %0d expected 10", lat); end
        checks++; if (bus.vram_addr_o !== 16'h10F1) begin errors++; $display("FAIL cold_addr: got %h expected 10f1", bus.vram_addr_o); end
        checks++; if (bus.vram_mask_o !== 4'b0100) begin errors++; $display("FAIL cold_mask: got %b expected 0100", bus.vram_mask_o); end
        checks++; if (bus.vram_data_o !== 16'hAAAA) begin errors++; $display("FAIL cold_data: got %h expected aaaa", bus.vram_data_o); end
        checks++; if ({bus.vram_wr_o, busy_o, bus.pix_ready_o} !== 3'b110) begin errors++; $display("FAIL cold_wr_busy_ready: got %b expected 110", {bus.vram_wr_o, busy_o, bus.pix_ready_o}); end
        do_ack();
        checks++; if ({bus.vram_sel_o, bus.pix_ready_o, busy_o} !== 3'b010) begin errors++; $display("FAIL cold_after_ack: got %b expected 010", {bus.vram_sel_o, bus.pix_ready_o, busy_o}); end
    endtask

    task automatic test_row_step();
        int lat;
        do_point(10'd6, 10'd4, 4'h5, 1'b0, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL step_dn_lat: got %0d expected 0", lat); end
        checks++; if (bus.vram_addr_o !== 16'h1141) begin errors++; $display("FAIL step_dn_addr: got %h expected 1141", bus.vram_addr_o); end
        checks++; if ({bus.vram_mask_o, bus.vram_data_o} !== {4'b0010, 16'h5555}) begin errors++; $display("FAIL step_dn_mask_data: got %h expected 25555", {bus.vram_mask_o, bus.vram_data_o}); end
        do_ack();
        do_point(10'd6, 10'd3, 4'h1, 1'b0, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL step_up_lat: got %0d expected 0", lat); end
        checks++; if (bus.vram_addr_o !== 16'h10F1) begin errors++; $display("FAIL step_up_addr: got %h expected 10f1", bus.vram_addr_o); end
        do_ack();
        do_point(10'd7, 10'd3, 4'hF, 1'b0, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL hit_lat: got %0d expected 0", lat); end
        checks++; if ({bus.vram_addr_o, bus.vram_mask_o} !== {16'h10F1, 4'b0001}) begin errors++; $display("FAIL hit_addr_mask: got %h expected 10f11", {bus.vram_addr_o, bus.vram_mask_o}); end
        do_ack();
        do_point(10'd4, 10'd3, 4'h2, 1'b1, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL inval_accept_lat: got %0d expected 10", lat); end
        checks++; if ({bus.vram_addr_o, bus.vram_mask_o} !== {16'h10F1, 4'b1000}) begin errors++; $display("FAIL inval_accept_addr: got %h expected 10f18", {bus.vram_addr_o, bus.vram_mask_o}); end
        do_ack();
    endtask

    task automatic test_clipping();
        int lat;
        logic [9:0] cx[3];
        logic [9:0] cy[3];
        cx = '{10'd320, 10'h3FF, 10'd0};
        cy = '{10'd0, 10'd5, 10'd240};
        bus.pix_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.x_i = cx[i];
            bus.y_i = cy[i];
            checks++; if (bus.pix_ready_o !== 1'b1) begin errors++; $display("FAIL clip_ready_pre%0d: got %b expected 1", i, bus.pix_ready_o); end
            @(posedge clk); #1;
            checks++; if ({bus.vram_sel_o, bus.pix_ready_o, busy_o} !== 3'b010) begin errors++; $display("FAIL clip_point%0d: got %b expected 010", i, {bus.vram_sel_o, bus.pix_ready_o, busy_o}); end
        end
        bus.pix_valid_i = 1'b0;
        do_point(10'd0, 10'd2, 4'h7, 1'b0, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL clip_then_miss_lat: got %0d expected 10", lat); end
        checks++; if ({bus.vram_addr_o, bus.vram_mask_o} !== {16'h10A0, 4'b1000}) begin errors++; $display("FAIL clip_then_miss_addr: got %h expected 10a08", {bus.vram_addr_o, bus.vram_mask_o}); end
        do_ack();
        do_point(10'd319, 10'd2, 4'h7, 1'b0, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL clip_xmax_lat: got %0d expected 0", lat); end
        checks++; if ({bus.vram_addr_o, bus.vram_mask_o} !== {16'h10EF, 4'b0001}) begin errors++; $display("FAIL clip_xmax_addr: got %h expected 10ef1", {bus.vram_addr_o, bus.vram_mask_o}); end
        do_ack();
        width_i = 10'd0;
        do_point(10'd5, 10'd2, 4'h7, 1'b0, lat);
        checks++; if (lat !== -1) begin errors++; $display("FAIL clip_width0: got %0d expected -1 (no write)", lat); end
        checks++; if (bus.pix_ready_o !== 1'b1) begin errors++; $display("FAIL clip_width0_ready: got %b expected 1", bus.pix_ready_o); end
        width_i = 10'd320;
        do_point(10'd0, 10'd239, 4'h7, 1'b0, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL clip_ymax_lat: got %0d expected 10", lat); end
        checks++; if (bus.vram_addr_o !== 16'h5AB0) begin errors++; $display("FAIL clip_ymax_addr: got %h expected 5ab0", bus.vram_addr_o); end
        do_ack();
    endtask

    task automatic test_ack_stall();
        int lat;
        do_point(10'd9, 10'd239, 4'hC, 1'b0, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL stall_lat: got %0d expected 0", lat); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.vram_sel_o, bus.vram_wr_o, bus.pix_ready_o, bus.vram_addr_o, bus.vram_mask_o, bus.vram_data_o}
                !== {3'b110, 16'h5AB2, 4'b0100, 16'hCCCC}) begin
                errors++;
                $display("FAIL stall_cycle%0d: got %h expected %h", i,
                         {bus.vram_sel_o, bus.vram_wr_o, bus.pix_ready_o, bus.vram_addr_o, bus.vram_mask_o, bus.vram_data_o},
                         {3'b110, 16'h5AB2, 4'b0100, 16'hCCCC});
            end
            @(posedge clk); #1;
        end
        do_ack();
        checks++; if ({bus.vram_sel_o, bus.pix_ready_o} !== 2'b01) begin errors++; $display("FAIL stall_ack: got %b expected 01", {bus.vram_sel_o, bus.pix_ready_o}); end
        bus.vram_ack_i = 1'b1;
        @(posedge clk); #1;
        bus.vram_ack_i = 1'b0;
        checks++; if ({bus.vram_sel_o, bus.pix_ready_o, busy_o} !== 3'b010) begin errors++; $display("FAIL idle_ack_ignored: got %b expected 010", {bus.vram_sel_o, bus.pix_ready_o, busy_o}); end
    endtask

    task automatic test_reset_mid_write();
        int lat;
        do_point(10'd10, 10'd239, 4'h3, 1'b0, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL rmw_pre_lat: got %0d expected 0", lat); end
        reset_n_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if ({bus.vram_sel_o, bus.pix_ready_o, busy_o} !== 3'b000) begin errors++; $display("FAIL rmw_in_reset%0d: got %b expected 000", i, {bus.vram_sel_o, bus.pix_ready_o, busy_o}); end
        end
        reset_n_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.pix_ready_o !== 1'b1) begin errors++; $display("FAIL rmw_release_ready: got %b expected 1", bus.pix_ready_o); end
        do_point(10'd10, 10'd239, 4'h3, 1'b0, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL rmw_miss_lat: got %0d expected 10", lat); end
        checks++; if ({bus.vram_addr_o, bus.vram_mask_o} !== {16'h5AB2, 4'b0010}) begin errors++; $display("FAIL rmw_addr: got %h expected 5ab22", {bus.vram_addr_o, bus.vram_mask_o}); end
        do_ack();
    endtask

    task automatic test_line();
        int lat;
        int w0;
        int lx[8];
        int ly[8];
        logic [15:0] la[8];
        logic [3:0] lm[8];
        lx = '{0, 1, 2, 3, 4, 5, 6, 7};
        ly = '{0, 0, 1, 1, 1, 1, 2, 2};
        la = '{16'h0000, 16'h0000, 16'h0050, 16'h0050, 16'h0051, 16'h0051, 16'h00A1, 16'h00A1};
        lm = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        base_addr_i = 16'h0000;
        stride_i = 16'd80;
        pulse_inval();
        w0 = writes;
        for (int i = 0; i < 8; i++) begin
            do_point(10'(lx[i]), 10'(ly[i]), 4'(i), 1'b0, lat);
            checks++; if (lat !== ((i == 0) ? 10 : 0)) begin errors++; $display("FAIL line_lat%0d: got %0d expected %0d", i, lat, (i == 0) ? 10 : 0); end
            checks++; if ({bus.vram_addr_o, bus.vram_mask_o} !== {la[i], lm[i]}) begin errors++; $display("FAIL line_write%0d: got %h expected %h", i, {bus.vram_addr_o, bus.vram_mask_o}, {la[i], lm[i]}); end
            do_ack();
        end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (writes - w0 !== 8) begin errors++; $display("FAIL line_write_count: got %0d expected 8", writes - w0); end
        checks++; if (bus.vram_sel_o !== 1'b0) begin errors++; $display("FAIL line_idle_sel: got %b expected 0", bus.vram_sel_o); end
    endtask

    initial begin
        bus.pix_valid_i = 1'b0;
        bus.x_i = '0;
        bus.y_i = '0;
        bus.color_i = '0;
        bus.vram_ack_i = 1'b0;
        test_reset();
        test_cold_miss();
        test_row_step();
        test_clipping();
        test_ack_stall();
        test_reset_mid_write();
        test_line();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
